// File: rtl/user_press_counter.sv
`default_nettype none
// ============================================================================
// Module      : user_press_counter (+ helper user_press_counter_debounce)
// Description : Debounces the player's tap button and counts presses while
//               the answer window is open. The count saturates at MAX_COUNT,
//               freezes on postSig and is held (countValid=1) until the next
//               answerSig.
// Build option: USER_COUNT_DECREMENT_EN adds a debounced undo button
//               (btnDecRaw) that decrements the count, saturating at 0.
// Revision    : 1.0 - initial release
// ============================================================================

// Synchronizer + stability-counter debouncer; rise_o marks a debounced 0->1.
module user_press_counter_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic rise_o
);
  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES,
  // so the comparison is against DEBOUNCE_CYCLES-1 held in the register.
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  logic               sync1_q;
  logic               sync2_q;
  logic               level_q;
  logic               level_d;
  logic               level_dly_q;
  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;

  // Count consecutive cycles of disagreement; flip the level once stable long enough
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == c_CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + c_CNT_ONE;
      end
    end
  end

  // Synchronizer flops, debounced level, delayed level for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
    end
  end

  // Release (1->0) is debounced too but never reported
  assign rise_o = level_q & ~level_dly_q;

endmodule

module user_press_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_COUNT       = 99
) (
  input  logic       Clk100M,
  input  logic       resetN,
  input  logic       btnRaw,
  input  logic       btnDecRaw,
  input  logic       answerSig,
  input  logic       postSig,
  output logic [7:0] userCount,
  output logic       pressPulse,
  output logic       countValid
);
  localparam logic [7:0] c_MAX  = 8'(MAX_COUNT);
  localparam logic [7:0] c_ZERO = 8'd0;
  localparam logic [7:0] c_ONE  = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] count_q;
  logic [7:0] count_d;
  logic       pulse_q;
  logic       pulse_d;
  logic       valid_q;
  logic       valid_d;

  logic       w_inc_press;
  logic       w_dec_press;

  user_press_counter_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_tap_deb (
    .clk_i   (Clk100M),
    .rst_n_i (resetN),
    .btn_i   (btnRaw),
    .rise_o  (w_inc_press)
  );

`ifdef USER_COUNT_DECREMENT_EN
  user_press_counter_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_undo_deb (
    .clk_i   (Clk100M),
    .rst_n_i (resetN),
    .btn_i   (btnDecRaw),
    .rise_o  (w_dec_press)
  );
`else
  // Undo button is not part of this build; the port is kept for a fixed pinout
  logic w_unused_btn_dec;
  assign w_unused_btn_dec = btnDecRaw;
  assign w_dec_press      = 1'b0;
`endif

  // Window control and count update; presses outside COUNTING are dropped
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pulse_d = 1'b0;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (answerSig) begin
          state_d = ST_COUNTING;
          count_d = c_ZERO;
          valid_d = 1'b0;
        end
      end
      ST_COUNTING: begin
        if (postSig) begin
          // Closing wins over a press landing in the same cycle
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end else if (w_inc_press && !w_dec_press) begin
          if (count_q < c_MAX) begin
            count_d = count_q + c_ONE;
            pulse_d = 1'b1;
          end
        end else if (w_dec_press && !w_inc_press) begin
          if (count_q != c_ZERO) begin
            count_d = count_q - c_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clk100M) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      count_q <= c_ZERO;
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
      valid_q <= valid_d;
    end
  end

  assign userCount  = count_q;
  assign pressPulse = pulse_q;
  assign countValid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_user_press_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_press_counter
// Description : Randomised self-checking bench for user_press_counter with a
//               sample-level reference model and a pulse scoreboard.
// Build option: USER_COUNT_DECREMENT_EN enables the undo-button scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_press_counter;
  localparam int D   = 4;
  localparam int MAX = 99;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       btnRaw = 1'b0;
  logic       btnDecRaw = 1'b0;
  logic       answerSig = 1'b0;
  logic       postSig = 1'b0;
  logic [7:0] userCount;
  logic       pressPulse;
  logic       countValid;

  int n_tests = 0;
  int n_fail  = 0;

  user_press_counter #(
    .DEBOUNCE_CYCLES(D),
    .MAX_COUNT      (MAX)
  ) dut (
    .Clk100M   (clk),
    .resetN    (resetN),
    .btnRaw    (btnRaw),
    .btnDecRaw (btnDecRaw),
    .answerSig (answerSig),
    .postSig   (postSig),
    .userCount (userCount),
    .pressPulse(pressPulse),
    .countValid(countValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button level is accepted after D consecutive raw samples at the new
  // value; an accepted rise reaches the counter three edges after the sample
  // that completed the run (two synchronizer stages plus edge detection).
  int       run[2];
  bit       lvl[2];
  bit [2:0] pipe[2];
  bit       raw[2];
  bit       now[2];
  bit       m_open  = 1'b0;
  int       m_cnt   = 0;
  bit       m_valid = 1'b0;
  int       m_pulses = 0;
  int       exp_q[$];

  always @(posedge clk) begin
    raw[0] = btnRaw;
    raw[1] = btnDecRaw;
    if (!resetN) begin
      for (int b = 0; b < 2; b++) begin
        run[b] = 0; lvl[b] = 1'b0; pipe[b] = 3'b000;
      end
      m_open = 1'b0; m_cnt = 0; m_valid = 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        now[b]  = pipe[b][2];
        pipe[b] = {pipe[b][1:0], 1'b0};
        if (raw[b] == lvl[b]) run[b] = 0;
        else begin
          run[b]++;
          if (run[b] == D) begin
            lvl[b]     = ~lvl[b];
            run[b]     = 0;
            pipe[b][0] = lvl[b];
          end
        end
      end
`ifndef USER_COUNT_DECREMENT_EN
      now[1] = 1'b0;
`endif
      if (!m_open) begin
        if (answerSig) begin m_open = 1'b1; m_cnt = 0; m_valid = 1'b0; end
      end else if (postSig) begin
        m_open = 1'b0; m_valid = 1'b1;
      end else if (now[0] && !now[1]) begin
        if (m_cnt < MAX) begin
          m_cnt++; m_pulses++; exp_q.push_back(m_cnt);
        end
      end else if (now[1] && !now[0]) begin
        if (m_cnt > 0) m_cnt--;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int n_dut_pulses = 0;
  bit prev_pulse   = 1'b0;
  always @(negedge clk) begin
    if (pressPulse) begin
      n_dut_pulses++;
      chk("pulse_not_adjacent", prev_pulse, 0);
      if (exp_q.size() == 0) chk("unexpected_pulse", 1, 0);
      else chk("count_at_pulse", userCount, exp_q.pop_front());
    end
    prev_pulse = pressPulse;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    btnRaw = 1'b1; cyc(hi);
    btnRaw = 1'b0; cyc(lo);
  endtask

  task automatic close_window();
    answerSig = 1'b0; postSig = 1'b1; cyc(1);
    postSig = 1'b0;
  endtask

  logic [9:0] obs;
  int         base;

  initial begin
    cyc(3);
    chk("reset_count", userCount, 0);
    chk("reset_pulse", pressPulse, 0);
    chk("reset_valid", countValid, 0);
    resetN = 1'b1; cyc(2);
    answerSig = 1'b1; cyc(1);
    chk("window_start_count", userCount, 0);

    // Clean 20-cycle press: single pulse 6 edges after the first sample
    btnRaw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); obs[i] = pressPulse;
    end
    chk("pulse_timing", int'(obs), 64);
    cyc(10); btnRaw = 1'b0; cyc(10);
    chk("clean_press", userCount, 1);

    // Bounce every 2 cycles, then hold: exactly one more press
    for (int i = 0; i < 15; i++) begin btnRaw = ~btnRaw; cyc(2); end
    btnRaw = 1'b1; cyc(10); btnRaw = 1'b0; cyc(10);
    chk("bounce_press", userCount, 2);
    chk("bounce_model", userCount, m_cnt);

    // Saturation at MAX
    close_window(); cyc(2);
    chk("hold_valid", countValid, 1);
    answerSig = 1'b1; cyc(1);
    chk("restart_count", userCount, 0);
    chk("restart_valid", countValid, 0);
    base = n_dut_pulses;
    repeat (105) press($urandom_range(4, 8), $urandom_range(4, 8));
    cyc(10);
    chk("saturate_count", userCount, 99);
    chk("saturate_pulses", n_dut_pulses - base, 99);

    // postSig coincident with the 4th debounced press
    close_window(); answerSig = 1'b1; cyc(1);
    repeat (3) press(6, 6);
    btnRaw = 1'b1; cyc(6);
    postSig = 1'b1; answerSig = 1'b0; cyc(1);
    postSig = 1'b0; cyc(4); btnRaw = 1'b0; cyc(8);
    chk("coincident_count", userCount, 3);
    chk("coincident_valid", countValid, 1);
    repeat (2) press(6, 6);
    chk("hold_ignores_press", userCount, 3);
    answerSig = 1'b1; cyc(1);
    chk("new_window_count", userCount, 0);
    chk("new_window_valid", countValid, 0);

    // Reset mid-window with count 7
    repeat (7) press(5, 5);
    chk("pre_reset_count", userCount, 7);
    resetN = 1'b0; answerSig = 1'b0; cyc(1);
    resetN = 1'b1;
    chk("midreset_count", userCount, 0);
    chk("midreset_pulse", pressPulse, 0);
    chk("midreset_valid", countValid, 0);
    repeat (2) press(6, 6);
    chk("idle_ignores_press", userCount, 0);
    answerSig = 1'b1; cyc(1);
    press(6, 6);
    chk("after_reset_press", userCount, 1);

`ifdef USER_COUNT_DECREMENT_EN
    close_window(); answerSig = 1'b1; cyc(1);
    repeat (2) press(6, 6);
    repeat (3) begin btnDecRaw = 1'b1; cyc(6); btnDecRaw = 1'b0; cyc(6); end
    chk("undo_saturate_zero", userCount, 0);
    press(6, 6);
    btnRaw = 1'b1; btnDecRaw = 1'b1; cyc(6);
    btnRaw = 1'b0; btnDecRaw = 1'b0; cyc(6);
    chk("tap_undo_cancel", userCount, 1);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      btnRaw    = 1'($urandom_range(0, 1));
      btnDecRaw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) answerSig = ~answerSig;
      if ($urandom_range(0, 15) == 0) begin
        postSig = 1'b1; cyc(1); postSig = 1'b0;
      end
      cyc($urandom_range(1, 8));
      if (i % 20 == 19) begin
        chk("random_count", userCount, m_cnt);
        chk("random_valid", countValid, int'(m_valid));
      end
    end
    btnRaw = 1'b0; btnDecRaw = 1'b0; postSig = 1'b0; cyc(20);
    chk("final_count", userCount, m_cnt);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("total_pulses", n_dut_pulses, m_pulses);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
